// File: rtl/bids_round_sequencer_pkg.sv
// Shared types and constants for the BIDS22 round sequencer: operation codes,
// sequencer states and status, host register addresses and the ready timeout.
package BIDS22pkg;

    typedef enum logic [3:0] {
        No_op        = 4'd0,
        Unlock_op    = 4'd1,
        Lock_op      = 4'd2,
        LoadX_op     = 4'd3,
        LoadY_op     = 4'd4,
        LoadZ_op     = 4'd5,
        SetTimer_op  = 4'd6,
        BidCharge_op = 4'd7
    } operation_t;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_RDY, START, WAIT_OVER, CAPTURE, FAIL
    } seq_state_t;

    typedef enum logic [1:0] {
        OK, DUT_ERR, TIMEOUT, ABORTED
    } seq_status_t;

    localparam logic [2:0] ADDR_KEY    = 3'd0;
    localparam logic [2:0] ADDR_LOADX  = 3'd1;
    localparam logic [2:0] ADDR_LOADY  = 3'd2;
    localparam logic [2:0] ADDR_LOADZ  = 3'd3;
    localparam logic [2:0] ADDR_TIMER  = 3'd4;
    localparam logic [2:0] ADDR_CHARGE = 3'd5;

    localparam logic [2:0] LAST_STEP   = 3'd6;
    localparam int         RDY_TIMEOUT = 32;

    // Steps 0..5 line up with register addresses; step 6 re-locks with the key.
    function automatic operation_t stepOp(input logic [2:0] step);
        case (step)
            3'd0:    stepOp = Unlock_op;
            3'd1:    stepOp = LoadX_op;
            3'd2:    stepOp = LoadY_op;
            3'd3:    stepOp = LoadZ_op;
            3'd4:    stepOp = SetTimer_op;
            3'd5:    stepOp = BidCharge_op;
            3'd6:    stepOp = Lock_op;
            default: stepOp = No_op;
        endcase
    endfunction

endpackage

// File: rtl/bids_round_sequencer_wdog.sv
// Ready watchdog: counts consecutive enabled cycles and flags the last allowed one.
module bids_wdog #(
    parameter int RDY_TIMEOUT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(RDY_TIMEOUT);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // High during the final permitted cycle so the FSM leaves on the edge ending it.
    assign expired = enable && (r_count == CW'(RDY_TIMEOUT - 1));

endmodule

// File: rtl/bids_round_sequencer.sv
// Host-driven sequencer that programs BIDS22 through its seven-op setup table,
// runs one bidding round and reports the captured result or failure cause.
module bids_round_sequencer
    import BIDS22pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        h_wr,
    input  logic [2:0]  h_addr,
    input  logic [31:0] h_wdata,
    input  logic        h_go,
    input  logic        h_abort,
    output logic        h_busy,
    output logic        h_done,
    output seq_status_t h_status,
    output logic [2:0]  h_err,
    output logic [31:0] h_maxBid,
    output logic [2:0]  h_win,
    output operation_t  C_op,
    output logic [31:0] C_data,
    output logic        C_start,
    input  logic        ready,
    input  logic        roundOver,
    input  logic [2:0]  err,
    input  logic [31:0] maxBid,
    input  logic        X_win,
    input  logic        Y_win,
    input  logic        Z_win
);

    seq_state_t  r_state;
    seq_state_t  w_nextState;
    logic [2:0]  r_step;
    logic [31:0] r_cfg [0:5];
    seq_status_t r_status;
    logic [2:0]  r_err;
    logic [2:0]  r_win;
    logic [31:0] r_maxBid;
    logic        w_abort;
    logic        w_inWait;
    logic        w_wdogExpired;
    logic [2:0]  w_dataSel;

    assign w_abort   = h_abort && (r_state != IDLE);
    assign w_inWait  = (r_state == WAIT_RDY);
    assign w_dataSel = (r_step == LAST_STEP) ? ADDR_KEY : r_step;

    bids_wdog #(
        .RDY_TIMEOUT(RDY_TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!w_inWait),
        .enable  (w_inWait),
        .expired (w_wdogExpired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort overrides every other event, and err outranks ready while waiting.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:      if (h_go) w_nextState = ISSUE;
            ISSUE:     w_nextState = WAIT_RDY;
            WAIT_RDY: begin
                if (err != 3'd0)        w_nextState = FAIL;
                else if (ready)         w_nextState = (r_step == LAST_STEP) ? START : ISSUE;
                else if (w_wdogExpired) w_nextState = FAIL;
            end
            START:     w_nextState = WAIT_OVER;
            WAIT_OVER: if (roundOver) w_nextState = CAPTURE;
            CAPTURE:   w_nextState = IDLE;
            FAIL:      w_nextState = IDLE;
            default:   w_nextState = IDLE;
        endcase
        if (w_abort) w_nextState = FAIL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= 3'd0;
        end else if (r_state == IDLE && h_go) begin
            r_step <= 3'd0;
        end else if (r_state == WAIT_RDY && w_nextState == ISSUE) begin
            r_step <= r_step + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 6; i++) r_cfg[i] <= 32'd0;
        end else if (h_wr && r_state == IDLE && h_addr <= ADDR_CHARGE) begin
            r_cfg[h_addr] <= h_wdata;
        end
    end

    // Result registers load on the edge entering CAPTURE/FAIL so they are valid with h_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_status <= OK;
            r_err    <= 3'd0;
            r_maxBid <= 32'd0;
            r_win    <= 3'd0;
        end else if (w_abort) begin
            r_status <= ABORTED;
        end else if (r_state == WAIT_RDY && w_nextState == FAIL) begin
            if (err != 3'd0) begin
                r_status <= DUT_ERR;
                r_err    <= err;
            end else begin
                r_status <= TIMEOUT;
            end
        end else if (w_nextState == CAPTURE) begin
            r_status <= OK;
            r_maxBid <= maxBid;
            r_win    <= {X_win, Y_win, Z_win};
        end
    end

    always_comb begin
        C_op   = No_op;
        C_data = 32'd0;
        if (r_state == ISSUE) begin
            C_op   = stepOp(r_step);
            C_data = r_cfg[w_dataSel];
        end
    end

    assign C_start  = (r_state == START) || (r_state == WAIT_OVER);
    assign h_busy   = (r_state != IDLE);
    assign h_done   = (r_state == CAPTURE) || (r_state == FAIL);
    assign h_status = r_status;
    assign h_err    = r_err;
    assign h_maxBid = r_maxBid;
    assign h_win    = r_win;

endmodule

// File: tb/tb_bids_round_sequencer.sv
// Directed bench for bids_round_sequencer with a simple BIDS22 responder model.
module tb_bids_round_sequencer;
    import BIDS22pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        h_wr;
    logic [2:0]  h_addr;
    logic [31:0] h_wdata;
    logic        h_go;
    logic        h_abort;
    logic        h_busy;
    logic        h_done;
    seq_status_t h_status;
    logic [2:0]  h_err;
    logic [31:0] h_maxBid;
    logic [2:0]  h_win;
    operation_t  C_op;
    logic [31:0] C_data;
    logic        C_start;
    logic        ready;
    logic        roundOver;
    logic [2:0]  err;
    logic [31:0] maxBid;
    logic        X_win, Y_win, Z_win;

    int checks = 0;
    int errors = 0;

    int          cycle, opCount, startCount, doneCount, doneCycle;
    operation_t  opLog [16];
    logic [31:0] dataLog [16];
    bit          prevOp;
    int          errAfter, stallAfter, roundLen;
    logic [2:0]  errCode;

    bids_round_sequencer dut (
        .clk(clk), .reset(reset),
        .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_go(h_go), .h_abort(h_abort),
        .h_busy(h_busy), .h_done(h_done), .h_status(h_status),
        .h_err(h_err), .h_maxBid(h_maxBid), .h_win(h_win),
        .C_op(C_op), .C_data(C_data), .C_start(C_start),
        .ready(ready), .roundOver(roundOver), .err(err),
        .maxBid(maxBid), .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    // One negedge: answer the previous op, log the current one, track round and done.
    task automatic cycleStep();
        @(negedge clk);
        cycle++;
        ready = 1'b0;
        err   = 3'd0;
        if (prevOp) begin
            if (opCount - 1 == errAfter)        err = errCode;
            else if (opCount - 1 != stallAfter) ready = 1'b1;
        end
        prevOp = (C_op != No_op);
        if (C_op != No_op && opCount < 16) begin
            opLog[opCount]   = C_op;
            dataLog[opCount] = C_data;
            opCount++;
        end
        if (C_start) startCount++;
        roundOver = C_start && (startCount >= roundLen);
        if (h_done) begin
            doneCount++;
            doneCycle = cycle;
        end
    endtask

    task automatic startSession(input bit withWr, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        h_go = 1'b1;
        h_wr = withWr; h_addr = a; h_wdata = d;
        cycle = 0; opCount = 0; startCount = 0; doneCount = 0; doneCycle = -1;
        prevOp = 1'b0; ready = 1'b0; err = 3'd0; roundOver = 1'b0;
        cycleStep();
        h_go = 1'b0;
        h_wr = 1'b0;
    endtask

    task automatic runUntilDone(input int budget);
        for (int i = 0; i < budget && doneCount == 0; i++) cycleStep();
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        h_wr = 1'b1; h_addr = a; h_wdata = d;
        @(negedge clk);
        h_wr = 1'b0;
    endtask

    task automatic setResponder(input int errIdx, input int stallIdx, input int rLen);
        errAfter = errIdx; stallAfter = stallIdx; roundLen = rLen;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (h_busy !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", h_busy); end
        checks++; if (h_done !== 1'b0)    begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", h_done); end
        checks++; if (h_status !== OK)    begin errors++; $display("[TB] FAIL reset_status: got %0d want 0", h_status); end
        checks++; if (C_op !== No_op)     begin errors++; $display("[TB] FAIL reset_cop: got %0d want 0", C_op); end
        checks++; if (C_start !== 1'b0)   begin errors++; $display("[TB] FAIL reset_cstart: got %0b want 0", C_start); end
        checks++; if (h_maxBid !== 32'd0) begin errors++; $display("[TB] FAIL reset_maxbid: got %0h want 0", h_maxBid); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_main();
        operation_t  expOp   [7];
        logic [31:0] expData [7];
        expOp   = '{Unlock_op, LoadX_op, LoadY_op, LoadZ_op, SetTimer_op, BidCharge_op, Lock_op};
        expData = '{32'hA5A5_0001, 32'd100, 32'd200, 32'd300, 32'd20, 32'd1, 32'hA5A5_0001};
        maxBid = 32'h50; X_win = 1'b0; Y_win = 1'b1; Z_win = 1'b0;
        setResponder(-1, -1, 26);
        startSession(1'b0, 3'd0, 32'd0);
        runUntilDone(80);
        checks++; if (opCount !== 7) begin errors++; $display("[TB] FAIL main_opcount: got %0d want 7", opCount); end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (opLog[i] !== expOp[i]) begin errors++; $display("[TB] FAIL main_op%0d: got %0d want %0d", i, opLog[i], expOp[i]); end
            checks++;
            if (dataLog[i] !== expData[i]) begin errors++; $display("[TB] FAIL main_data%0d: got %0h want %0h", i, dataLog[i], expData[i]); end
        end
        checks++; if (startCount !== 26) begin errors++; $display("[TB] FAIL main_cstart_cycles: got %0d want 26", startCount); end
        checks++; if (doneCycle !== 41)  begin errors++; $display("[TB] FAIL main_done_cycle: got %0d want 41", doneCycle); end
        cycleStep(); cycleStep();
        checks++; if (doneCount !== 1)        begin errors++; $display("[TB] FAIL main_done_pulses: got %0d want 1", doneCount); end
        checks++; if (h_status !== OK)        begin errors++; $display("[TB] FAIL main_status: got %0d want 0", h_status); end
        checks++; if (h_maxBid !== 32'h50)    begin errors++; $display("[TB] FAIL main_maxbid: got %0h want 50", h_maxBid); end
        checks++; if (h_win !== 3'b010)       begin errors++; $display("[TB] FAIL main_win: got %b want 010", h_win); end
        checks++; if (h_busy !== 1'b0)        begin errors++; $display("[TB] FAIL main_busy_after: got %0b want 0", h_busy); end
    endtask

    task automatic test_dut_err();
        maxBid = 32'hDEAD; X_win = 1'b1; Y_win = 1'b0; Z_win = 1'b1;
        errCode = 3'b001;
        setResponder(2, -1, 26);
        startSession(1'b0, 3'd0, 32'd0);
        runUntilDone(40);
        checks++; if (doneCycle !== 7)        begin errors++; $display("[TB] FAIL err_done_cycle: got %0d want 7", doneCycle); end
        checks++; if (opCount !== 3)          begin errors++; $display("[TB] FAIL err_opcount: got %0d want 3", opCount); end
        cycleStep(); cycleStep();
        checks++; if (h_status !== DUT_ERR)   begin errors++; $display("[TB] FAIL err_status: got %0d want 1", h_status); end
        checks++; if (h_err !== 3'b001)       begin errors++; $display("[TB] FAIL err_code: got %0d want 1", h_err); end
        checks++; if (h_maxBid !== 32'h50)    begin errors++; $display("[TB] FAIL err_maxbid_kept: got %0h want 50", h_maxBid); end
        checks++; if (h_win !== 3'b010)       begin errors++; $display("[TB] FAIL err_win_kept: got %b want 010", h_win); end
        checks++; if (doneCount !== 1)        begin errors++; $display("[TB] FAIL err_done_pulses: got %0d want 1", doneCount); end
    endtask

    task automatic test_timeout();
        setResponder(-1, 0, 26);
        startSession(1'b0, 3'd0, 32'd0);
        runUntilDone(60);
        checks++; if (doneCycle !== 34)       begin errors++; $display("[TB] FAIL tmo_done_cycle: got %0d want 34", doneCycle); end
        checks++; if (opCount !== 1)          begin errors++; $display("[TB] FAIL tmo_opcount: got %0d want 1", opCount); end
        cycleStep();
        checks++; if (h_status !== TIMEOUT)   begin errors++; $display("[TB] FAIL tmo_status: got %0d want 2", h_status); end
        checks++; if (h_maxBid !== 32'h50)    begin errors++; $display("[TB] FAIL tmo_maxbid_kept: got %0h want 50", h_maxBid); end
    endtask

    task automatic test_abort();
        maxBid = 32'h77; X_win = 1'b1; Y_win = 1'b0; Z_win = 1'b1;
        setResponder(-1, -1, 1000);
        startSession(1'b0, 3'd0, 32'd0);
        for (int i = 0; i < 40 && startCount < 5; i++) cycleStep();
        checks++; if (C_start !== 1'b1)       begin errors++; $display("[TB] FAIL abort_cstart_before: got %0b want 1", C_start); end
        h_abort = 1'b1;
        cycleStep();
        h_abort = 1'b0;
        checks++; if (C_start !== 1'b0)       begin errors++; $display("[TB] FAIL abort_cstart_after: got %0b want 0", C_start); end
        checks++; if (h_done !== 1'b1)        begin errors++; $display("[TB] FAIL abort_done: got %0b want 1", h_done); end
        cycleStep();
        checks++; if (h_status !== ABORTED)   begin errors++; $display("[TB] FAIL abort_status: got %0d want 3", h_status); end
        checks++; if (h_maxBid !== 32'h50)    begin errors++; $display("[TB] FAIL abort_maxbid_kept: got %0h want 50", h_maxBid); end
        checks++; if (h_win !== 3'b010)       begin errors++; $display("[TB] FAIL abort_win_kept: got %b want 010", h_win); end
        checks++; if (h_busy !== 1'b0)        begin errors++; $display("[TB] FAIL abort_busy: got %0b want 0", h_busy); end
    endtask

    task automatic test_busy_ignore();
        setResponder(-1, -1, 5);
        startSession(1'b0, 3'd0, 32'd0);
        repeat (3) cycleStep();
        h_wr = 1'b1; h_addr = ADDR_LOADX; h_wdata = 32'h55;
        cycleStep();
        h_wr = 1'b0;
        cycleStep();
        h_go = 1'b1;
        cycleStep();
        h_go = 1'b0;
        runUntilDone(60);
        checks++; if (opCount !== 7)          begin errors++; $display("[TB] FAIL busy_opcount: got %0d want 7", opCount); end
        checks++; if (doneCount !== 1)        begin errors++; $display("[TB] FAIL busy_done: got %0d want 1", doneCount); end
        repeat (2) cycleStep();
        startSession(1'b0, 3'd0, 32'd0);
        runUntilDone(60);
        checks++; if (opLog[1] !== LoadX_op)  begin errors++; $display("[TB] FAIL busy_next_op1: got %0d want 3", opLog[1]); end
        checks++; if (dataLog[1] !== 32'd100) begin errors++; $display("[TB] FAIL busy_next_loadx: got %0h want 64", dataLog[1]); end
        checks++; if (doneCycle !== 20)       begin errors++; $display("[TB] FAIL busy_next_done_cycle: got %0d want 20", doneCycle); end
        repeat (2) cycleStep();
    endtask

    task automatic test_reset_mid();
        setResponder(-1, -1, 5);
        startSession(1'b0, 3'd0, 32'd0);
        for (int i = 0; i < 20 && opCount < 5; i++) cycleStep();
        checks++; if (C_op !== SetTimer_op)   begin errors++; $display("[TB] FAIL rst_mid_step4: got %0d want 6", C_op); end
        reset = 1'b1;
        cycleStep();
        checks++; if (h_busy !== 1'b0)        begin errors++; $display("[TB] FAIL rst_mid_busy: got %0b want 0", h_busy); end
        checks++; if (h_done !== 1'b0)        begin errors++; $display("[TB] FAIL rst_mid_done: got %0b want 0", h_done); end
        checks++; if (C_start !== 1'b0)       begin errors++; $display("[TB] FAIL rst_mid_cstart: got %0b want 0", C_start); end
        checks++; if (C_op !== No_op)         begin errors++; $display("[TB] FAIL rst_mid_cop: got %0d want 0", C_op); end
        checks++; if (C_data !== 32'd0)       begin errors++; $display("[TB] FAIL rst_mid_cdata: got %0h want 0", C_data); end
        checks++; if (h_status !== OK)        begin errors++; $display("[TB] FAIL rst_mid_status: got %0d want 0", h_status); end
        checks++; if (h_err !== 3'd0)         begin errors++; $display("[TB] FAIL rst_mid_err: got %0d want 0", h_err); end
        checks++; if (h_maxBid !== 32'd0)     begin errors++; $display("[TB] FAIL rst_mid_maxbid: got %0h want 0", h_maxBid); end
        checks++; if (h_win !== 3'd0)         begin errors++; $display("[TB] FAIL rst_mid_win: got %b want 000", h_win); end
        reset = 1'b0;
        repeat (5) cycleStep();
        checks++; if (doneCount !== 0)        begin errors++; $display("[TB] FAIL rst_mid_no_done: got %0d want 0", doneCount); end
        startSession(1'b1, ADDR_KEY, 32'h1234);
        runUntilDone(60);
        checks++; if (dataLog[0] !== 32'h1234) begin errors++; $display("[TB] FAIL wrgo_key: got %0h want 1234", dataLog[0]); end
        checks++; if (dataLog[1] !== 32'd0)    begin errors++; $display("[TB] FAIL rst_cfg_cleared: got %0h want 0", dataLog[1]); end
        checks++; if (dataLog[6] !== 32'h1234) begin errors++; $display("[TB] FAIL wrgo_lock_key: got %0h want 1234", dataLog[6]); end
        checks++; if (doneCount !== 1)         begin errors++; $display("[TB] FAIL wrgo_done: got %0d want 1", doneCount); end
    endtask

    initial begin
        reset = 1'b1; h_wr = 1'b0; h_addr = 3'd0; h_wdata = 32'd0;
        h_go = 1'b0; h_abort = 1'b0; ready = 1'b0; roundOver = 1'b0; err = 3'd0;
        maxBid = 32'd0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
        errCode = 3'd0; prevOp = 1'b0;
        cycle = 0; opCount = 0; startCount = 0; doneCount = 0; doneCycle = -1;
        errAfter = -1; stallAfter = -1; roundLen = 26;

        test_reset();
        writeReg(ADDR_KEY,    32'hA5A5_0001);
        writeReg(ADDR_LOADX,  32'd100);
        writeReg(ADDR_LOADY,  32'd200);
        writeReg(ADDR_LOADZ,  32'd300);
        writeReg(ADDR_TIMER,  32'd20);
        writeReg(ADDR_CHARGE, 32'd1);
        test_main();
        test_dut_err();
        test_timeout();
        test_abort();
        test_busy_ignore();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bids_round_sequencer.md
BIDS_ROUND_SEQUENCER -- requirements
Module: bids_round_sequencer

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), clock and reset first:
clk  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
h_wr  in  1  host config-register write strobe
h_addr  in  3  register select: 0 key, 1 loadX, 2 loadY, 3 loadZ, 4 timer, 5 bidCharge
h_wdata  in  32  write data
h_go  in  1  start-session pulse
h_abort  in  1  abort the current session
h_busy  out  1  session in progress
h_done  out  1  one-cycle session-complete pulse
h_status  out  2  seq_status_t: OK, DUT_ERR, TIMEOUT, ABORTED
h_err  out  3  BIDS22 err captured on DUT_ERR
h_maxBid  out  32  captured maxBid
h_win  out  3  captured {X_win,Y_win,Z_win}
C_op  out  4  operation_t to BIDS22
C_data  out  32  operand to BIDS22
C_start  out  1  round start to BIDS22
ready, roundOver  in  1 each  BIDS22 status
err  in  3  BIDS22 error code
maxBid  in  32  BIDS22 winning bid
X_win, Y_win, Z_win  in  1 each  BIDS22 winner flags

Function
REQ-002 Writes (h_wr) in IDLE SHALL update the addressed 32-bit register on the next edge; writes in any other state, and writes with h_addr 6-7, SHALL be ignored.
REQ-003 h_go in IDLE SHALL enter ISSUE with step=0 on the next edge; h_go in any other state SHALL be ignored; h_wr and h_go in the same cycle SHALL leave the session using the new register value.
REQ-004 States SHALL be IDLE, ISSUE, WAIT_RDY, START, WAIT_OVER, CAPTURE, FAIL.
REQ-005 Step table SHALL be: 0 Unlock_op/key, 1 LoadX_op/loadX, 2 LoadY_op/loadY, 3 LoadZ_op/loadZ, 4 SetTimer_op/timer, 5 BidCharge_op/bidCharge, 6 Lock_op/key.
REQ-006 ISSUE SHALL drive C_op/C_data from the step table for exactly one cycle, then go to WAIT_RDY; in every other state C_op SHALL be No_op and C_data SHALL be 0.
REQ-007 WAIT_RDY SHALL sample from the first cycle after ISSUE: err!=0 -> FAIL (DUT_ERR, h_err=err), taking priority over ready; else ready=1 -> step+1 and ISSUE, or START after step 6.
REQ-008 If ready is not seen within RDY_TIMEOUT=32 WAIT_RDY cycles, the block SHALL go to FAIL with status TIMEOUT.
REQ-009 START SHALL assert C_start=1; C_start SHALL stay high through WAIT_OVER until roundOver=1 is sampled, then go low on the next edge with the state moving to CAPTURE.
REQ-010 CAPTURE SHALL latch maxBid and {X_win,Y_win,Z_win}, set status OK, pulse h_done for one cycle and return to IDLE.
REQ-011 FAIL SHALL pulse h_done for one cycle, keep h_maxBid/h_win unchanged, force C_start=0 and return to IDLE.
REQ-012 h_abort in any state except IDLE SHALL go to FAIL with status ABORTED on the next edge, overriding err, ready and roundOver sampled in that cycle; h_abort in IDLE SHALL be ignored.
REQ-013 h_busy SHALL be 1 in every state except IDLE.
REQ-014 Best-case session latency from h_go to h_done SHALL be 2*7 + 3 cycles plus round duration, with ready=1 returned one cycle after each issue.

Reset
REQ-015 reset SHALL force IDLE, step=0, watchdog=0, all config registers 0, C_op=No_op, C_data=0, C_start=0, h_busy=0, h_done=0, h_status=OK, h_err=0, h_maxBid=0, h_win=0 on the next edge.
REQ-016 Reset mid-session SHALL abandon the session without an h_done pulse and SHALL drop C_start on that edge.

Structure
REQ-017 BIDS22pkg SHALL hold operation_t (No_op=0, Unlock_op=1, Lock_op=2, LoadX_op=3, LoadY_op=4, LoadZ_op=5, SetTimer_op=6, BidCharge_op=7), seq_state_t, seq_status_t, the register-address constants and RDY_TIMEOUT.
REQ-018 The ready watchdog SHALL be a sub-module, bids_wdog (clear, enable, expired), parameterised by RDY_TIMEOUT.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- key=0xA5A5_0001, loads 100/200/300, timer 20, charge 1, h_go, ready one cycle after each op, roundOver at cycle 40, maxBid=0x50, Y_win -> 7 ops in table order with the correct C_data, C_start high until roundOver, h_maxBid=0x50, h_win=3'b010, status OK.
- err=3'b001 returned after LoadY_op -> FAIL at step 2, h_err=1, status DUT_ERR, no SetTimer_op issued.
- ready held 0 after Unlock_op -> h_done exactly 32 cycles after WAIT_RDY entry, status TIMEOUT.
- h_abort during WAIT_OVER -> C_start low next edge, status ABORTED, h_maxBid keeps its previous value.
- h_wr addr 1 value 0x55 while busy, then h_go mid-session -> both ignored; the next session issues LoadX_op with the old value.
- reset asserted during step 4 -> all outputs at reset values next edge, no h_done pulse.
